// File: rtl/rv_g_pkg.sv
// Shared definitions for the rv_g register-file writeback path.
package rv_g_pkg;

    typedef logic [5:0] reg_addr_t;

    // Addresses at or above this value select the floating-point bank.
    localparam int unsigned FP_BASE = 32;

    function automatic int unsigned max_len(input int unsigned xlen, input int unsigned flen);
        return (xlen > flen) ? xlen : flen;
    endfunction

endpackage

// File: rtl/rv_g_wb_fifo.sv
// Small synchronous FIFO buffering completed results of one execution unit.
// A push is ignored while full and a pop is ignored while empty.
module rv_g_wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & (count_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // full_q is registered from the next count, so a pop in the same cycle
    // never frees a slot early; it reads as full during reset to refuse pushes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CntW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/rv_g_wb_arbiter.sv
// Round-robin writeback arbiter feeding the unified int/fp register-file
// write port from NUM_SRC buffered execution-unit result channels.
module rv_g_wb_arbiter
    import rv_g_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FLEN       = 32,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned MaxLen    = max_len(XLEN, FLEN)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_SRC-1:0]             src_valid_i,
    output logic [NUM_SRC-1:0]             src_ready_o,
    input  logic [NUM_SRC-1:0][5:0]        src_addr_i,
    input  logic [NUM_SRC-1:0][MaxLen-1:0] src_data_i,
    output logic                           wr_en_o,
    output logic [5:0]                     wr_addr_o,
    output logic [MaxLen-1:0]              wr_data_o,
    output logic                           busy_o
);

    localparam int unsigned EntW = 6 + MaxLen;
    localparam int unsigned SrcW = $clog2(NUM_SRC);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [EntW-1:0]    pop_data [NUM_SRC];
    logic [CntW-1:0]    count    [NUM_SRC];
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] pop;

    logic [SrcW-1:0]    rr_q, rr_d;
    logic [SrcW:0]      cand;
    logic               grant_valid;
    logic [SrcW-1:0]    grant_idx;

    logic [EntW-1:0]    sel_entry;
    reg_addr_t          sel_addr;
    logic [MaxLen-1:0]  sel_data;
    logic [MaxLen-1:0]  int_mask;
    logic [MaxLen-1:0]  wr_data_d;
    logic               any_pending;

    logic               wr_en_q;
    reg_addr_t          wr_addr_q;
    logic [MaxLen-1:0]  wr_data_q;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        rv_g_wb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (EntW)
        ) u_fifo (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .push_i      (src_valid_i[s]),
            .push_data_i ({src_addr_i[s], src_data_i[s]}),
            .pop_i       (pop[s]),
            .pop_data_o  (pop_data[s]),
            .full_o      (full[s]),
            .empty_o     (empty[s]),
            .count_o     (count[s])
        );
    end

    assign src_ready_o = ~full;

    // Search upward from rr_q, wrapping modulo NUM_SRC, for the first non-empty FIFO.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, rr_q} + (SrcW + 1)'(i);
            if (cand >= (SrcW + 1)'(NUM_SRC)) begin
                cand = cand - (SrcW + 1)'(NUM_SRC);
            end
            if (!grant_valid && !empty[cand[SrcW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[SrcW-1:0];
            end
        end
    end

    always_comb begin
        pop  = '0;
        rr_d = rr_q;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            pop[s] = grant_valid && (grant_idx == SrcW'(s));
        end
        if (grant_valid) begin
            rr_d = (grant_idx == SrcW'(NUM_SRC - 1)) ? '0 : grant_idx + SrcW'(1);
        end
    end

    // Integer destinations narrower than MaxLen get their upper bits cleared.
    always_comb begin
        int_mask = '0;
        for (int unsigned b = 0; b < MaxLen; b++) begin
            int_mask[b] = (b < XLEN);
        end
    end

    assign sel_entry = pop_data[grant_idx];
    assign sel_addr  = sel_entry[EntW-1 -: 6];
    assign sel_data  = sel_entry[MaxLen-1:0];
    assign wr_data_d = (sel_addr >= reg_addr_t'(FP_BASE)) ? sel_data : (sel_data & int_mask);

    always_comb begin
        any_pending = 1'b0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            any_pending = any_pending | (count[s] != '0);
        end
    end

    // x0 results still consume their grant slot but never raise the write strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wr_en_q <= grant_valid && (sel_addr != '0);
            if (grant_valid) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= wr_data_d;
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = any_pending | wr_en_q;

endmodule

// File: tb/tb_rv_g_wb_arbiter.sv
// Directed and randomized bench for rv_g_wb_arbiter (XLEN=32, FLEN=64) checked
// against a queue-based model of the round-robin writeback rules.
module tb_rv_g_wb_arbiter;

    localparam int NumSrc = 4;
    localparam int Depth  = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NumSrc-1:0]        srcValid = '0;
    logic [NumSrc-1:0]        srcReady;
    logic [NumSrc-1:0][5:0]   srcAddr = '0;
    logic [NumSrc-1:0][63:0]  srcData = '0;
    logic                     wrEn;
    logic [5:0]               wrAddr;
    logic [63:0]              wrData;
    logic                     busy;

    rv_g_wb_arbiter #(
        .XLEN       (32),
        .FLEN       (64),
        .NUM_SRC    (NumSrc),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_valid_i (srcValid),
        .src_ready_o (srcReady),
        .src_addr_i  (srcAddr),
        .src_data_i  (srcData),
        .wr_en_o     (wrEn),
        .wr_addr_o   (wrAddr),
        .wr_data_o   (wrData),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         src;
        logic [5:0] addr;
        logic [63:0] data;
    } entry_t;

    // Model: one global arrival-ordered queue tagged by source.
    entry_t            mq[$];
    int                mrr = 0;
    logic              expEn = 1'b0;
    logic [5:0]        expAddr = '0;
    logic [63:0]       expData = '0;
    logic [NumSrc-1:0] expReady = '0;
    logic              expBusy = 1'b0;
    logic              inReset = 1'b1;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    function automatic int modelSize(input int s);
        int n = 0;
        foreach (mq[k]) if (mq[k].src == s) n++;
        return n;
    endfunction

    task automatic modelStep(input logic r, input logic [NumSrc-1:0] v,
                             input logic [NumSrc-1:0][5:0] a, input logic [NumSrc-1:0][63:0] d);
        entry_t e;
        logic   popped = 1'b0;
        if (r) begin
            mq.delete();
            mrr = 0; expEn = 1'b0; expAddr = '0; expData = '0;
            expReady = '0; expBusy = 1'b0; inReset = 1'b1;
            return;
        end
        inReset = 1'b0;
        expEn = 1'b0;
        for (int i = 0; i < NumSrc && !popped; i++) begin
            int s = (mrr + i) % NumSrc;
            for (int k = 0; k < mq.size(); k++) begin
                if (mq[k].src == s) begin
                    e = mq[k];
                    mq.delete(k);
                    popped = 1'b1;
                    mrr = (s + 1) % NumSrc;
                    break;
                end
            end
        end
        for (int s = 0; s < NumSrc; s++) begin
            if (v[s] && expReady[s]) mq.push_back('{s, a[s], d[s]});
        end
        if (popped) begin
            expEn   = (e.addr != 0);
            expAddr = e.addr;
            expData = (e.addr >= 32) ? e.data : {32'h0, e.data[31:0]};
        end
        for (int s = 0; s < NumSrc; s++) expReady[s] = (modelSize(s) < Depth);
        expBusy = (mq.size() != 0) || expEn;
    endtask

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("wr_en", {63'h0, wrEn}, {63'h0, expEn});
        checkValue("src_ready", {60'h0, srcReady}, {60'h0, expReady});
        checkValue("busy", {63'h0, busy}, {63'h0, expBusy});
        if (expEn || inReset) begin
            checkValue("wr_addr", {58'h0, wrAddr}, {58'h0, expAddr});
            checkValue("wr_data", wrData, expData);
        end
    endtask

    // Drive at the falling edge, let one rising edge consume it, check at the next falling edge.
    task automatic applyStimulus(input logic r, input logic [NumSrc-1:0] v,
                                 input logic [NumSrc-1:0][5:0] a, input logic [NumSrc-1:0][63:0] d);
        rst = r; srcValid = v; srcAddr = a; srcData = d;
        modelStep(r, v, a, d);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, '0, '0, '0);
    endtask

    task automatic randomInputs(output logic [NumSrc-1:0] v, output logic [NumSrc-1:0][5:0] a,
                                output logic [NumSrc-1:0][63:0] d);
        v = 4'($urandom_range(0, 15));
        for (int s = 0; s < NumSrc; s++) begin
            a[s] = 6'($urandom_range(0, 63));
            d[s] = {$urandom(), $urandom()};
        end
    endtask

    initial begin
        logic [NumSrc-1:0]       v;
        logic [NumSrc-1:0][5:0]  a;
        logic [NumSrc-1:0][63:0] d;
        logic [5:0]              obsOrder[$];
        int                      bpIdx;
        int                      acceptedAtDrop;
        logic                    accept;

        $display("[TB] reset with random source activity");
        for (int k = 0; k < 3; k++) begin
            randomInputs(v, a, d);
            applyStimulus(1'b1, v, a, d);
            checkValue("rst_ready", {60'h0, srcReady}, 64'h0);
        end

        $display("[TB] single write");
        idleStep();
        v = 4'b0010; a = '0; d = '0; a[1] = 6'd5; d[1] = 64'hDEADBEEF;
        applyStimulus(1'b0, v, a, d);
        checkValue("single_e0_en", {63'h0, wrEn}, 64'h0);
        idleStep();
        checkValue("single_en", {63'h0, wrEn}, 64'h1);
        checkValue("single_addr", {58'h0, wrAddr}, 64'd5);
        checkValue("single_data", wrData, 64'hDEADBEEF);
        idleStep();
        checkValue("single_after_en", {63'h0, wrEn}, 64'h0);

        // A lone grant to the last source brings the pointer back to 0.
        v = 4'b1000; a = '0; d = '0; a[3] = 6'd9;
        applyStimulus(1'b0, v, a, d);
        idleStep();
        idleStep();

        $display("[TB] round-robin bursts");
        for (int burst = 0; burst < 2; burst++) begin
            v = 4'b1111;
            for (int s = 0; s < NumSrc; s++) begin
                a[s] = 6'(burst * 4 + s + 1);
                d[s] = {$urandom(), $urandom()};
            end
            applyStimulus(1'b0, v, a, d);
            for (int k = 0; k < NumSrc; k++) begin
                idleStep();
                checkValue("rr_en", {63'h0, wrEn}, 64'h1);
                checkValue("rr_addr", {58'h0, wrAddr}, 64'(burst * 4 + k + 1));
            end
        end
        idleStep();

        $display("[TB] backpressure on source 0");
        v = 4'b1110; a = '0; d = '0;
        for (int s = 1; s < NumSrc; s++) a[s] = 6'(20 + s);
        applyStimulus(1'b0, v, a, d);
        applyStimulus(1'b0, v, a, d);
        bpIdx = 0;
        acceptedAtDrop = -1;
        for (int cyc = 0; cyc < 40 && obsOrder.size() < 3; cyc++) begin
            v = '0; a = '0; d = '0;
            if (bpIdx < 3) begin
                if (srcReady[0] === 1'b0 && acceptedAtDrop < 0) acceptedAtDrop = bpIdx;
                v = 4'b1111;
                a[0] = 6'(10 + bpIdx);
                d[0] = {$urandom(), $urandom()};
                for (int s = 1; s < NumSrc; s++) begin
                    a[s] = 6'(20 + s);
                    d[s] = {$urandom(), $urandom()};
                end
            end
            accept = v[0] && expReady[0];
            applyStimulus(1'b0, v, a, d);
            if (accept) bpIdx++;
            if (wrEn === 1'b1 && wrAddr >= 6'd10 && wrAddr <= 6'd12) obsOrder.push_back(wrAddr);
        end
        checkValue("bp_drop_after", 64'(acceptedAtDrop), 64'd2);
        checkValue("bp_written", 64'(obsOrder.size()), 64'd3);
        foreach (obsOrder[i]) checkValue("bp_order", {58'h0, obsOrder[i]}, 64'(10 + i));
        for (int k = 0; k < 30 && expBusy; k++) idleStep();
        checkValue("bp_drained", {63'h0, busy}, 64'h0);

        $display("[TB] width rule and x0");
        v = 4'b0001; a = '0; d = '0; a[0] = 6'd3; d[0] = '1;
        applyStimulus(1'b0, v, a, d);
        idleStep();
        checkValue("int_en", {63'h0, wrEn}, 64'h1);
        checkValue("int_width", wrData, 64'h00000000FFFFFFFF);
        a[0] = 6'd35;
        applyStimulus(1'b0, v, a, d);
        idleStep();
        checkValue("fp_en", {63'h0, wrEn}, 64'h1);
        checkValue("fp_width", wrData, 64'hFFFFFFFFFFFFFFFF);
        a[0] = 6'd0;
        applyStimulus(1'b0, v, a, d);
        checkValue("x0_busy_queued", {63'h0, busy}, 64'h1);
        idleStep();
        checkValue("x0_en", {63'h0, wrEn}, 64'h0);
        checkValue("x0_busy", {63'h0, busy}, 64'h0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            randomInputs(v, a, d);
            applyStimulus(1'b0, v, a, d);
        end

        $display("[TB] reset mid-operation");
        for (int k = 0; k < 4; k++) begin
            v = 4'b1111;
            for (int s = 0; s < NumSrc; s++) begin
                a[s] = 6'($urandom_range(1, 63));
                d[s] = {$urandom(), $urandom()};
            end
            applyStimulus(1'b0, v, a, d);
        end
        randomInputs(v, a, d);
        applyStimulus(1'b1, v, a, d);
        checkValue("rst_mid_en", {63'h0, wrEn}, 64'h0);
        checkValue("rst_mid_busy", {63'h0, busy}, 64'h0);
        applyStimulus(1'b1, v, a, d);
        for (int k = 0; k < 5; k++) begin
            idleStep();
            checkValue("rst_mid_no_write", {63'h0, wrEn}, 64'h0);
            checkValue("rst_mid_idle", {63'h0, busy}, 64'h0);
        end
        v = 4'b0100; a = '0; d = '0; a[2] = 6'd7; d[2] = 64'h0123456789ABCDEF;
        applyStimulus(1'b0, v, a, d);
        checkValue("fresh_e0_en", {63'h0, wrEn}, 64'h0);
        idleStep();
        checkValue("fresh_en", {63'h0, wrEn}, 64'h1);
        checkValue("fresh_addr", {58'h0, wrAddr}, 64'd7);
        checkValue("fresh_data", wrData, 64'h0000000089ABCDEF);
        idleStep();
        checkValue("fresh_after_en", {63'h0, wrEn}, 64'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
